// File: rtl/mips_perf_pkg.sv
// Shared constants and types for the MIPS performance-counter unit.
package mips_perf_pkg;

    localparam logic [4:0] GCTRL_ADDR = 5'd16;
    localparam logic [4:0] OVF_ADDR   = 5'd17;

    localparam int GCTRL_GEN_BIT = 0;
    localparam int GCTRL_CLR_BIT = 1;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_SAT_BIT    = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;
    localparam int CTRL_SEL_LSB    = 4;
    localparam int EVT_SEL_W       = 4;

    localparam int EVT_CYCLE    = 0;
    localparam int EVT_RETIRE   = 1;
    localparam int EVT_LOAD     = 2;
    localparam int EVT_STORE    = 3;
    localparam int EVT_BR_TAKEN = 4;

    typedef struct packed {
        logic [EVT_SEL_W-1:0] evt_sel;
        logic                 irq_en;
        logic                 sat;
        logic                 en;
    } ctrl_t;

endpackage

// File: rtl/perf_cnt_slice.sv
// One programmable counter: CTRL register, event select, COUNT with
// wrap/saturate handling and a one-cycle overflow pulse to the top level.
module perf_cnt_slice
    import mips_perf_pkg::*;
#(
    parameter int   CNT_W   = 32,
    parameter int   NUM_EVT = 8,
    parameter logic RST_EN  = 1'b0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               gen,
    input  logic               clr,
    input  logic [NUM_EVT-1:0] evt_in,
    input  logic               ctrl_we,
    input  logic               cnt_we,
    input  logic [31:0]        wdata,
    output logic [31:0]        ctrl_rdata,
    output logic [CNT_W-1:0]   count,
    output logic               irq_en,
    output logic               ovf_set
);

    localparam logic [CNT_W-1:0] ONE = 1;
    localparam ctrl_t CTRL_RST = '{evt_sel: '0, irq_en: 1'b0, sat: 1'b0, en: RST_EN};

    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             evt_hit;
    logic             inc;

    // Selects beyond the implemented event inputs never match, giving a constant 0 event.
    always_comb begin
        evt_hit = 1'b0;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (ctrl_q.evt_sel == EVT_SEL_W'(k)) begin
                evt_hit = evt_in[k];
            end
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrl_we) begin
            ctrl_d.en      = wdata[CTRL_EN_BIT];
            ctrl_d.sat     = wdata[CTRL_SAT_BIT];
            ctrl_d.irq_en  = wdata[CTRL_IRQ_EN_BIT];
            ctrl_d.evt_sel = wdata[CTRL_SEL_LSB +: EVT_SEL_W];
        end
    end

    always_comb begin
        inc     = gen & ctrl_q.en & evt_hit;
        count_d = count_q;
        ovf_set = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (cnt_we) begin
            count_d = wdata[CNT_W-1:0];
        end else if (inc) begin
            if (&count_q) begin
                ovf_set = 1'b1;
                count_d = ctrl_q.sat ? count_q : '0;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_q  <= CTRL_RST;
            count_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        ctrl_rdata                                = '0;
        ctrl_rdata[CTRL_EN_BIT]                   = ctrl_q.en;
        ctrl_rdata[CTRL_SAT_BIT]                  = ctrl_q.sat;
        ctrl_rdata[CTRL_IRQ_EN_BIT]               = ctrl_q.irq_en;
        ctrl_rdata[CTRL_SEL_LSB +: EVT_SEL_W]     = ctrl_q.evt_sel;
    end

    assign count  = count_q;
    assign irq_en = ctrl_q.irq_en;

endmodule

// File: rtl/mips_perf_cnt_unit.sv
// Performance-counter unit top: register decode, GCTRL, OVF, read port and irq,
// with one perf_cnt_slice per counter.
module mips_perf_cnt_unit
    import mips_perf_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 32,
    parameter int NUM_EVT = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_EVT-1:0] evt_in,
    input  logic               cfg_we,
    input  logic               cfg_re,
    input  logic [4:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               cfg_rvalid,
    output logic               irq
);

    logic               gen_q, gen_d;
    logic [NUM_CNT-1:0] ovf_q, ovf_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               irq_q, irq_d;

    logic               gctrl_we, ovf_we, clr;
    logic [NUM_CNT-1:0] ctrl_we, cnt_we, ovf_set, irq_en_v;
    logic [31:0]        ctrl_rd [NUM_CNT];
    logic [CNT_W-1:0]   count_v [NUM_CNT];
    logic [31:0]        rd_mux;

    assign gctrl_we = cfg_we && (cfg_addr == GCTRL_ADDR);
    assign ovf_we   = cfg_we && (cfg_addr == OVF_ADDR);
    assign clr      = gctrl_we && cfg_wdata[GCTRL_CLR_BIT];

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        assign ctrl_we[i] = cfg_we && (cfg_addr == 5'(2 * i));
        assign cnt_we[i]  = cfg_we && (cfg_addr == 5'(2 * i + 1));

        perf_cnt_slice #(
            .CNT_W   (CNT_W),
            .NUM_EVT (NUM_EVT),
            .RST_EN  ((i == 0) ? 1'b1 : 1'b0)
        ) u_slice (
            .clk        (clk),
            .resetn     (resetn),
            .gen        (gen_q),
            .clr        (clr),
            .evt_in     (evt_in),
            .ctrl_we    (ctrl_we[i]),
            .cnt_we     (cnt_we[i]),
            .wdata      (cfg_wdata),
            .ctrl_rdata (ctrl_rd[i]),
            .count      (count_v[i]),
            .irq_en     (irq_en_v[i]),
            .ovf_set    (ovf_set[i])
        );
    end

    always_comb begin
        gen_d = gen_q;
        if (gctrl_we) begin
            gen_d = cfg_wdata[GCTRL_GEN_BIT];
        end
    end

    // A fresh overflow in the same cycle as its W1C keeps the bit set.
    always_comb begin
        ovf_d = ovf_q;
        if (clr) begin
            ovf_d = '0;
        end else begin
            if (ovf_we) begin
                ovf_d = ovf_q & ~cfg_wdata[NUM_CNT-1:0];
            end
            ovf_d = ovf_d | ovf_set;
        end
    end

    assign irq_d = |(ovf_q & irq_en_v);

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (cfg_addr == 5'(2 * i)) begin
                rd_mux = ctrl_rd[i];
            end
            if (cfg_addr == 5'(2 * i + 1)) begin
                rd_mux = 32'(count_v[i]);
            end
        end
        if (cfg_addr == GCTRL_ADDR) begin
            rd_mux = 32'(gen_q);
        end
        if (cfg_addr == OVF_ADDR) begin
            rd_mux = 32'(ovf_q);
        end
    end

    assign rdata_d  = cfg_re ? rd_mux : rdata_q;
    assign rvalid_d = cfg_re;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gen_q    <= 1'b1;
            ovf_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            gen_q    <= gen_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
        end
    end

    assign cfg_rdata  = rdata_q;
    assign cfg_rvalid = rvalid_q;
    assign irq        = irq_q;

endmodule
